mux_sel_sequencer: RTL

Round-robin channel sequencer that sits directly upstream of the gate-level 4:1 mux. It drives the mux select pair {A,B} and tells the downstream sampler when the mux output Y is valid. Each requesting channel gets a fixed dwell of DWELL accepted samples. Between channels there is one settle cycle, so Y is never sampled while the select is changing.

---
 rtl/mux_seq_pkg.sv | 11 +
 rtl/rr_arb4.sv | 30 +++
 rtl/mux_sel_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared constants and FSM state type for the mux select sequencer
package mux_seq_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        XFER = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - combinational 4-way round-robin picker with optional channel-0 priority
import mux_seq_pkg::*;

module rr_arb4 (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              prio0,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);
    logic [SEL_W-1:0] cand;

    // Search order is ptr+1, ptr+2, ptr+3, ptr; the last slot re-grants the previous owner.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        if (prio0 && req[0]) begin
            found = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_CH; i++) begin
                cand = ptr + SEL_W'(i);
                if (!found && req[cand]) begin
                    found = 1'b1;
                    idx   = cand;
                end
            end
        end
    end
endmodule

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - round-robin mux select sequencer with settle cycle; MUX_SEQ_PRIO0_EN gives channel 0 priority
import mux_seq_pkg::*;

module mux_sel_sequencer #(
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              ready,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] gnt,
    output logic              valid,
    output logic              last
);
    localparam int BEAT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(DWELL - 1);

`ifdef MUX_SEQ_PRIO0_EN
    localparam logic PRIO0 = 1'b1;
`else
    localparam logic PRIO0 = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [SEL_W-1:0]    arb_ptr;
    logic [SEL_W-1:0]    arb_idx;
    logic                arb_found;
    logic                dwell_done;

    assign valid      = (state_q == XFER);
    assign last       = valid && (beat_q == BEAT_LAST);
    assign dwell_done = last && ready;
    assign sel        = sel_q;
    assign gnt        = gnt_q;

    // Back-to-back arbitration must search from the channel just finished; channel-0
    // priority grants leave the rotation pointer alone.
    assign arb_ptr = (dwell_done && !(PRIO0 && sel_q == '0)) ? sel_q : ptr_q;

    rr_arb4 u_arb (
        .req   (req),
        .ptr   (arb_ptr),
        .prio0 (PRIO0),
        .idx   (arb_idx),
        .found (arb_found)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    sel_d   = arb_idx;
                    gnt_d   = NUM_CH'(1) << arb_idx;
                    state_d = SEL;
                end
            end
            SEL: begin
                state_d = XFER;
            end
            XFER: begin
                if (ready) begin
                    if (last) begin
                        beat_d = '0;
                        ptr_d  = arb_ptr;
                        if (arb_found) begin
                            sel_d   = arb_idx;
                            gnt_d   = NUM_CH'(1) << arb_idx;
                            state_d = SEL;
                        end else begin
                            gnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            beat_q  <= '0;
            ptr_q   <= SEL_W'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule
